// File: rtl/snp_bus_arb_if.sv
// Cache-side and memory-side handshake bundle for snp_bus_arb.
// The arbiter connects through the slave modport; the cache/memory side uses master.
interface snp_bus_arb_if #(
  parameter int unsigned NUM_CAC     = 4,
  parameter int unsigned PADDR_WIDTH = 64,
  parameter int unsigned BLK_WIDTH   = 512,
  parameter int unsigned SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8)
);
  // Per-cache downstream request channel
  logic [NUM_CAC-1:0]             sdreq_valid;
  logic [3*NUM_CAC-1:0]           sdreq_op;
  logic [SADDR_WIDTH*NUM_CAC-1:0] sdreq_addr;
  logic [BLK_WIDTH*NUM_CAC-1:0]   sdreq_data;
  logic [NUM_CAC-1:0]             sdreq_ready;

  // Per-cache upstream response channel, payload shared by all caches
  logic [NUM_CAC-1:0]   sursp_valid;
  logic [2:0]           sursp_rsp;
  logic [BLK_WIDTH-1:0] sursp_data;
  logic [NUM_CAC-1:0]   sursp_ready;

  // Memory-side request/response
  logic                   mreq_valid;
  logic [2:0]             mreq_op;
  logic [SADDR_WIDTH-1:0] mreq_addr;
  logic [BLK_WIDTH-1:0]   mreq_data;
  logic                   mreq_ready;
  logic                   mrsp_valid;
  logic [2:0]             mrsp_rsp;
  logic [BLK_WIDTH-1:0]   mrsp_data;
  logic                   mrsp_ready;

  modport slave (
    input  sdreq_valid, sdreq_op, sdreq_addr, sdreq_data, sursp_ready,
    input  mreq_ready, mrsp_valid, mrsp_rsp, mrsp_data,
    output sdreq_ready, sursp_valid, sursp_rsp, sursp_data,
    output mreq_valid, mreq_op, mreq_addr, mreq_data, mrsp_ready
  );

  modport master (
    output sdreq_valid, sdreq_op, sdreq_addr, sdreq_data, sursp_ready,
    output mreq_ready, mrsp_valid, mrsp_rsp, mrsp_data,
    input  sdreq_ready, sursp_valid, sursp_rsp, sursp_data,
    input  mreq_valid, mreq_op, mreq_addr, mreq_data, mrsp_ready
  );
endinterface

// File: rtl/snp_bus_arb.sv
// Round-robin, one-transaction-in-flight arbiter sharing a single memory request
// channel between NUM_CAC caches; all handshake outputs come straight from flops.
module snp_bus_arb #(
  parameter int unsigned NUM_CAC     = 4,
  parameter int unsigned PADDR_WIDTH = 64,
  parameter int unsigned BLK_WIDTH   = 512,
  parameter int unsigned SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8),
  parameter int unsigned ID_WIDTH    = $clog2(NUM_CAC)
) (
  input  logic                clk,
  input  logic                rst,
  snp_bus_arb_if.slave        bus,
  output logic                busy,
  output logic [ID_WIDTH-1:0] gnt_id
);

  typedef enum logic [2:0] {
    ArbIdle,
    ArbAcpt,
    ArbFwd,
    ArbWait,
    ArbRet
  } arb_state_e;

  arb_state_e             state_q;
  logic [ID_WIDTH-1:0]    rr_ptr_q;
  logic [ID_WIDTH-1:0]    gnt_id_q;
  logic [NUM_CAC-1:0]     sdreq_ready_q;
  logic [NUM_CAC-1:0]     sursp_valid_q;
  logic                   mreq_valid_q;
  logic                   mrsp_ready_q;
  logic [2:0]             buf_op_q;
  logic [SADDR_WIDTH-1:0] buf_addr_q;
  logic [BLK_WIDTH-1:0]   buf_data_q;
  logic [2:0]             rsp_q;
  logic [BLK_WIDTH-1:0]   rsp_data_q;

  // Round-robin pick: first requester at or above rr_ptr_q, wrapping.
  logic                pick_hit;
  logic [ID_WIDTH-1:0] pick_id;
  logic [ID_WIDTH-1:0] scan_id;

  always_comb begin
    pick_hit = 1'b0;
    pick_id  = '0;
    scan_id  = '0;
    for (int unsigned k = 0; k < NUM_CAC; k++) begin
      scan_id = ID_WIDTH'((32'(rr_ptr_q) + k) % NUM_CAC);
      if (!pick_hit && bus.sdreq_valid[scan_id]) begin
        pick_hit = 1'b1;
        pick_id  = scan_id;
      end
    end
  end

  int unsigned            gnt_idx;
  logic [2:0]             gnt_op;
  logic [SADDR_WIDTH-1:0] gnt_addr;
  logic [BLK_WIDTH-1:0]   gnt_data;
  logic [ID_WIDTH-1:0]    gnt_next;

  assign gnt_idx  = 32'(gnt_id_q);
  assign gnt_op   = bus.sdreq_op[3*gnt_idx +: 3];
  assign gnt_addr = bus.sdreq_addr[SADDR_WIDTH*gnt_idx +: SADDR_WIDTH];
  assign gnt_data = bus.sdreq_data[BLK_WIDTH*gnt_idx +: BLK_WIDTH];
  assign gnt_next = (gnt_id_q == ID_WIDTH'(NUM_CAC - 1)) ? '0 : gnt_id_q + 1'b1;

  function automatic logic [NUM_CAC-1:0] id_onehot(logic [ID_WIDTH-1:0] id);
    return NUM_CAC'(1) << id;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ArbIdle;
      rr_ptr_q      <= '0;
      gnt_id_q      <= '0;
      sdreq_ready_q <= '0;
      sursp_valid_q <= '0;
      mreq_valid_q  <= 1'b0;
      mrsp_ready_q  <= 1'b0;
      buf_op_q      <= '0;
      buf_addr_q    <= '0;
      buf_data_q    <= '0;
      rsp_q         <= '0;
      rsp_data_q    <= '0;
    end else begin
      unique case (state_q)
        ArbIdle: begin
          if (pick_hit) begin
            gnt_id_q      <= pick_id;
            sdreq_ready_q <= id_onehot(pick_id);
            state_q       <= ArbAcpt;
          end
        end
        ArbAcpt: begin
          sdreq_ready_q <= '0;
          if (bus.sdreq_valid[gnt_id_q]) begin
            buf_op_q     <= gnt_op;
            buf_addr_q   <= gnt_addr;
            buf_data_q   <= gnt_data;
            mreq_valid_q <= 1'b1;
            state_q      <= ArbFwd;
          end else begin
            // Withdrawn request: no capture, pointer untouched.
            state_q <= ArbIdle;
          end
        end
        ArbFwd: begin
          if (bus.mreq_ready) begin
            mreq_valid_q <= 1'b0;
            mrsp_ready_q <= 1'b1;
            state_q      <= ArbWait;
          end
        end
        ArbWait: begin
          if (bus.mrsp_valid) begin
            rsp_q         <= bus.mrsp_rsp;
            rsp_data_q    <= bus.mrsp_data;
            mrsp_ready_q  <= 1'b0;
            sursp_valid_q <= id_onehot(gnt_id_q);
            state_q       <= ArbRet;
          end
        end
        ArbRet: begin
          if (bus.sursp_ready[gnt_id_q]) begin
            sursp_valid_q <= '0;
            rr_ptr_q      <= gnt_next;
            state_q       <= ArbIdle;
          end
        end
        default: state_q <= ArbIdle;
      endcase
    end
  end

  assign bus.sdreq_ready = sdreq_ready_q;
  assign bus.sursp_valid = sursp_valid_q;
  assign bus.sursp_rsp   = rsp_q;
  assign bus.sursp_data  = rsp_data_q;
  assign bus.mreq_valid  = mreq_valid_q;
  assign bus.mreq_op     = buf_op_q;
  assign bus.mreq_addr   = buf_addr_q;
  assign bus.mreq_data   = buf_data_q;
  assign bus.mrsp_ready  = mrsp_ready_q;
  assign busy            = (state_q != ArbIdle);
  assign gnt_id          = gnt_id_q;

endmodule

// File: tb/tb_snp_bus_arb.sv
// Directed plus randomized bench for snp_bus_arb; the bench plays both the caches
// and the memory, and predicts grants with a plain round-robin model.
module tb_snp_bus_arb;
  localparam int unsigned N  = 4;
  localparam int unsigned SW = 58;
  localparam int unsigned BW = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [1:0] gnt_id;

  int n_chk  = 0;
  int n_fail = 0;
  int rr_m   = 0;

  logic [3:0] pend = '0;

  snp_bus_arb_if #(.NUM_CAC(N), .PADDR_WIDTH(64), .BLK_WIDTH(BW), .SADDR_WIDTH(SW)) bus ();

  snp_bus_arb #(
    .NUM_CAC(N), .PADDR_WIDTH(64), .BLK_WIDTH(BW), .SADDR_WIDTH(SW), .ID_WIDTH(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy   (busy),
    .gnt_id (gnt_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_blk();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Plain round-robin reference: first set bit at or above ptr, modulo N.
  function automatic int model_pick(input logic [3:0] m, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (((m >> ((ptr + k) % 4)) & 4'd1) != 4'd0) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  logic [2:0]   req_op   [4];
  logic [57:0]  req_addr [4];
  logic [511:0] req_data [4];

  task automatic raise(input int id, input logic [2:0] op, input logic [57:0] addr,
                       input logic [511:0] data);
    req_op[id]   = op;
    req_addr[id] = addr;
    req_data[id] = data;
    bus.sdreq_op[3*id +: 3]     = op;
    bus.sdreq_addr[58*id +: 58] = addr;
    bus.sdreq_data[512*id +: 512] = data;
    bus.sdreq_valid[id] = 1'b1;
    pend[id] = 1'b1;
  endtask

  // Full transaction for cache id, starting with the DUT idle and id's request raised.
  task automatic do_txn(input int id, input int mstall, input int sstall,
                        input logic [2:0] rsp, input logic [511:0] rdata);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    tick();
    check("acpt_ready", bus.sdreq_ready, oh);
    check("acpt_gnt", gnt_id, id);
    check("acpt_busy", busy, 1'b1);
    tick();
    bus.sdreq_valid[id] = 1'b0;
    pend[id] = 1'b0;
    for (int s = 0; s <= mstall; s++) begin
      check("fwd_valid", bus.mreq_valid, 1'b1);
      check("fwd_op", bus.mreq_op, req_op[id]);
      check("fwd_addr", bus.mreq_addr, req_addr[id]);
      check("fwd_data", bus.mreq_data, req_data[id]);
      check("fwd_busy", busy, 1'b1);
      check("fwd_noready", bus.sdreq_ready, 4'b0000);
      if (s == mstall) bus.mreq_ready = 1'b1;
      tick();
    end
    bus.mreq_ready = 1'b0;
    check("wait_mrsp_ready", bus.mrsp_ready, 1'b1);
    check("wait_mreq_low", bus.mreq_valid, 1'b0);
    bus.mrsp_valid = 1'b1;
    bus.mrsp_rsp   = rsp;
    bus.mrsp_data  = rdata;
    tick();
    bus.mrsp_valid = 1'b0;
    bus.mrsp_rsp   = '0;
    bus.mrsp_data  = '0;
    bus.sursp_ready = ~oh;
    for (int s = 0; s <= sstall; s++) begin
      check("ret_valid", bus.sursp_valid, oh);
      check("ret_rsp", bus.sursp_rsp, rsp);
      check("ret_data", bus.sursp_data, rdata);
      check("ret_busy", busy, 1'b1);
      check("ret_noready", bus.sdreq_ready, 4'b0000);
      check("ret_mrsp_ready", bus.mrsp_ready, 1'b0);
      if (s == sstall) bus.sursp_ready = 4'b1111;
      tick();
    end
    bus.sursp_ready = '0;
    rr_m = (id + 1) % 4;
    check("idle_busy", busy, 1'b0);
    check("idle_sursp", bus.sursp_valid, 4'b0000);
    check("idle_rr", dut.rr_ptr_q, rr_m);
  endtask

  initial begin
    int id;
    bus.sdreq_valid = '0;
    bus.sdreq_op    = '0;
    bus.sdreq_addr  = '0;
    bus.sdreq_data  = '0;
    bus.sursp_ready = '0;
    bus.mreq_ready  = 1'b0;
    bus.mrsp_valid  = 1'b0;
    bus.mrsp_rsp    = '0;
    bus.mrsp_data   = '0;

    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check("rst_sdreq_ready", bus.sdreq_ready, 4'b0000);
    check("rst_sursp_valid", bus.sursp_valid, 4'b0000);
    check("rst_mreq_valid", bus.mreq_valid, 1'b0);
    check("rst_mrsp_ready", bus.mrsp_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_gnt", gnt_id, 2'd0);
    check("rst_sursp_rsp", bus.sursp_rsp, 3'd0);
    check("rst_sursp_data", bus.sursp_data, 512'd0);
    check("rst_mreq_addr", bus.mreq_addr, 58'd0);

    // Single request from cache 2
    raise(2, 3'b001, 58'h1234, rand_blk());
    do_txn(2, 0, 0, 3'b010, 512'hA5);
    check("single_rr", dut.rr_ptr_q, 2'd3);

    // Fairness: 0 and 3 together with pointer at 3
    raise(0, 3'b011, 58'h100, rand_blk());
    raise(3, 3'b100, 58'h300, rand_blk());
    do_txn(3, 0, 0, 3'b001, rand_blk());
    do_txn(0, 1, 1, 3'b110, rand_blk());

    // Backpressure on cache 1 while cache 2 waits
    raise(1, 3'b101, 58'h2_0000_0001, rand_blk());
    raise(2, 3'b010, 58'h3_dead_beef, rand_blk());
    do_txn(1, 5, 4, 3'b111, rand_blk());
    do_txn(2, 0, 0, 3'b000, rand_blk());

    // Withdrawal in ARB_ACPT
    raise(1, 3'b001, 58'h55, rand_blk());
    tick();
    check("wd_ready", bus.sdreq_ready, 4'b0010);
    bus.sdreq_valid[1] = 1'b0;
    pend[1] = 1'b0;
    tick();
    check("wd_busy", busy, 1'b0);
    check("wd_mreq", bus.mreq_valid, 1'b0);
    tick();
    check("wd_mreq2", bus.mreq_valid, 1'b0);
    check("wd_rr", dut.rr_ptr_q, rr_m);

    // Reset during ARB_WAIT
    raise(0, 3'b011, 58'h77, rand_blk());
    tick();
    check("rstw_gnt", gnt_id, 2'd0);
    tick();
    bus.sdreq_valid[0] = 1'b0;
    pend[0] = 1'b0;
    bus.mreq_ready = 1'b1;
    tick();
    bus.mreq_ready = 1'b0;
    check("rstw_in_wait", bus.mrsp_ready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr_m = 0;
    check("rstw_mrsp_ready", bus.mrsp_ready, 1'b0);
    check("rstw_mreq_valid", bus.mreq_valid, 1'b0);
    check("rstw_sursp_valid", bus.sursp_valid, 4'b0000);
    check("rstw_sdreq_ready", bus.sdreq_ready, 4'b0000);
    check("rstw_busy", busy, 1'b0);
    check("rstw_gnt", gnt_id, 2'd0);
    check("rstw_rr", dut.rr_ptr_q, 2'd0);

    // All four request and hold; then cache 0 again
    for (int i = 0; i < 4; i++) raise(i, 3'(i), 58'(i * 16 + 1), rand_blk());
    for (int i = 0; i < 4; i++) do_txn(i, i % 2, 0, 3'(7 - i), rand_blk());
    raise(0, 3'b110, 58'hABC, rand_blk());
    do_txn(0, 0, 0, 3'b011, rand_blk());

    // Randomized traffic against the round-robin model
    for (int t = 0; t < 40; t++) begin
      logic [3:0] add;
      add = 4'($urandom_range(0, 15));
      if ((pend | add) == 4'b0000) add = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < 4; i++) begin
        if (add[i] && !pend[i]) raise(i, 3'($urandom), {26'($urandom), 32'($urandom)}, rand_blk());
      end
      id = model_pick(pend, rr_m);
      do_txn(id, $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom), rand_blk());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
